bin_bcd_conv: RTL and testbench

Sequential binary-to-packed-BCD converter feeding the seven-segment decoder's 32-bit digit input (8 nibbles, digit 0 = least significant). Takes a raw binary sensor/count value, converts it by iterative shift-add-3 (double dabble), blanks leading zeros and flags out-of-range values. Sits between the measurement/counter logic and the segment decoder/driver chain.

---
 rtl/bin_bcd_conv.sv | 128 ++++++++++++
 tb/tb_bin_bcd_conv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_conv.sv
// bin_bcd_conv: sequential binary to packed-BCD converter (double dabble).
// Converts a BIN_W-bit binary value into DIGITS packed BCD nibbles (digit 0 is
// the least significant), optionally blanks leading zeros, and substitutes
// OVF_CODE in every digit when the value exceeds 10^DIGITS-1.
// Ports:
//   clk    system clock
//   rst    synchronous active-low reset
//   start  conversion request, sampled only while idle
//   bin    binary value, captured on an accepted start
//   busy   high while a conversion is in progress
//   done   one-cycle pulse when bcd/ovf have just been updated
//   bcd    packed BCD result, held until the next completion
//   ovf    last conversion overflowed; held alongside bcd
module bin_bcd_conv #(
  parameter int unsigned BIN_W      = 27,
  parameter int unsigned DIGITS     = 8,
  parameter bit          BLANK_LZ   = 1'b1,
  parameter logic [3:0]  BLANK_CODE = 4'hF,
  parameter logic [3:0]  OVF_CODE   = 4'hE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] max_val(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  function automatic logic [BCD_W-1:0] reset_bcd(input bit blank);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int unsigned i = 1; i < DIGITS; i++)
      if (blank) r[4*i +: 4] = BLANK_CODE;
    return r;
  endfunction

  localparam logic [63:0]      MAX_VAL = max_val(DIGITS);
  localparam logic [BCD_W-1:0] RST_BCD = reset_bcd(BLANK_LZ);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;

  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_blank;
  logic             seen;

  // Add-3 correction on every digit, all taken from the pre-shift value.
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  // Leading-zero blanking: scan from the MS digit down; digit 0 always shown.
  always_comb begin
    acc_blank = acc;
    seen      = 1'b0;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (acc[4*i +: 4] != 4'h0) seen = 1'b1;
      if (BLANK_LZ && !seen) acc_blank[4*i +: 4] = BLANK_CODE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= RST_BCD;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin;
            acc      <= '0;
            cnt      <= CNT_W'(BIN_W);
            ovf_pend <= (64'(bin) > MAX_VAL);
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          // MS accumulator bit falls off; only reachable on overflow.
          {acc, shreg} <= {acc_adj, shreg} << 1;
          cnt          <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIN;
        end
        FIN: begin
          if (ovf_pend) begin
            bcd <= {DIGITS{OVF_CODE}};
            ovf <= 1'b1;
          end else begin
            bcd <= acc_blank;
            ovf <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_bcd_conv.sv
module tb_bin_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [26:0] bin;
  logic        busy, done, ovf;
  logic [31:0] bcd;
  logic        busy_n, done_n, ovf_n;
  logic [31:0] bcd_n;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bin_bcd_conv #(.BIN_W(27), .DIGITS(8), .BLANK_LZ(1'b1), .BLANK_CODE(4'hF), .OVF_CODE(4'hE)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  bin_bcd_conv #(.BIN_W(27), .DIGITS(8), .BLANK_LZ(1'b0), .BLANK_CODE(4'hF), .OVF_CODE(4'hE)) dut_nolz (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy_n), .done(done_n), .bcd(bcd_n), .ovf(ovf_n)
  );

  // Reference: decimal digits by division, blank digits above the value's length.
  function automatic logic [31:0] model(input longint v, input bit blank);
    logic [31:0] r;
    longint      p;
    logic [3:0]  d;
    if (v > 64'd99999999) return 32'hEEEE_EEEE;
    r = '0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      d = 4'((v / p) % 10);
      if (blank && i > 0 && v < p) d = 4'hF;
      r[4*i +: 4] = d;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one conversion, wait (bounded) for done, check latency/busy/result.
  task automatic run_conv(input logic [26:0] v, input string tag);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd28);
    chk({tag, " busy cycles"}, 32'(bcnt), 32'd28);
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
    chk({tag, " bcd"}, bcd, model(longint'(v), 1'b1));
    chk({tag, " ovf"}, 32'(ovf), (longint'(v) > 99999999) ? 32'd1 : 32'd0);
    chk({tag, " bcd nolz"}, bcd_n, model(longint'(v), 1'b0));
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          dones, cyc;
    logic [31:0] held;
    logic [26:0] rv;

    rst   = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset bcd", bcd, 32'hFFFF_FFF0);
    chk("reset bcd nolz", bcd_n, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b1;

    // Directed values, including boundaries and overflow recovery.
    run_conv(27'd0, "zero");
    run_conv(27'd12345, "12345");
    run_conv(27'd99999999, "max");
    run_conv(27'd10000000, "interior zeros");
    run_conv(27'd1000, "1000");
    run_conv(27'd100000000, "ovf 1e8");
    chk("ovf 1e8 flag", 32'(ovf), 32'd1);
    run_conv(27'h7FF_FFFF, "ovf all ones");
    run_conv(27'd7, "after ovf");
    chk("after ovf flag", 32'(ovf), 32'd0);

    // Random values.
    for (int i = 0; i < 16; i++) begin
      rv = (i % 2 == 0) ? 27'($urandom_range(0, 999999)) : 27'($urandom);
      run_conv(rv, "random");
    end

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd42;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = 27'd99;
    chk("busy at cycle 10", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    held  = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        dones++;
        held = bcd;
      end
      @(posedge clk); #1;
    end
    chk("ignored start done count", 32'(dones), 32'd1);
    chk("ignored start bcd at done", held, 32'hFFFF_FF42);
    chk("ignored start bcd held", bcd, 32'hFFFF_FF42);
    chk("ignored start idle", 32'(busy), 32'd0);

    // Start held high: back-to-back conversions.
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd5;
    @(posedge clk); #1;
    bin = 27'd6;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b first done", 32'(done), 32'd1);
    chk("b2b first bcd", bcd, 32'hFFFF_FFF5);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b bcd held during second", bcd, 32'hFFFF_FFF5);
    chk("b2b second accepted", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b spacing", 32'(cyc), 32'd29);
    chk("b2b second bcd", bcd, 32'hFFFF_FFF6);

    // Reset mid-conversion aborts.
    run_conv(27'd555, "pre-abort");
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd8888;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort bcd", bcd, 32'hFFFF_FFF0);
    chk("abort ovf", 32'(ovf), 32'd0);
    chk("abort bcd nolz", bcd_n, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    run_conv(27'd2024, "after abort");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
